// File: rtl/mcp4725_i2c_responder.sv
// mcp4725_i2c_responder
//   I2C target that emulates the MCP4725 fast-write receiver. The external
//   SCL/SDA lines are synchronised, START/STOP and data bits are decoded, and
//   the target ACKs by pulling SDA low (open-drain). Each completed fast-write
//   byte pair updates a 12-bit DAC code.
//
//   Optional feature macro: MCP4725_PD_EN
//     defined     : pd carries bits[5:4] of the last accepted upper byte
//     not defined : pd is tied to 2'b00 and bits[5:4] are ignored
//
// Ports
//   clk        in   system clock (>= 16x SCL rate)
//   rst        in   asynchronous, active-high reset
//   scl        in   I2C clock line
//   sda_in     in   I2C data line as seen on the pad
//   sda_oe     out  1 = drive SDA low, 0 = release
//   dac_code   out  last accepted 12-bit DAC code
//   dac_valid  out  one-clock pulse when dac_code is updated
//   pd         out  power-down bits of the last accepted write
//   busy       out  high from an addressed START until the next STOP
module mcp4725_i2c_responder #(
  parameter logic [6:0] ADDR7       = 7'h60,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [11:0] dac_code,
  output logic        dac_valid,
  output logic [1:0]  pd,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_HI, S_HI_ACK, S_LO, S_LO_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [6:0]  shift_q;
  logic        ack_ph_q;
  logic        sda_oe_q;
  logic [11:0] dac_code_q;
  logic        dac_valid_q;
  logic        busy_q;
  logic [3:0]  code_hi_q;

  // Synchroniser and edge history. Reset to the idle-bus level (high) so
  // leaving reset never fabricates a bus condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_high, start_c, stop_c, scl_rise, scl_fall, in_ack;
  logic [7:0] byte_c;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  // SCL counts as high if either sample is high, so an SDA change coinciding
  // with an SCL edge is taken as a bus condition and the SCL edge is dropped.
  assign scl_high = scl_s | scl_prev_q;
  assign start_c  = scl_high & sda_prev_q & ~sda_s;
  assign stop_c   = scl_high & ~sda_prev_q & sda_s;
  assign scl_rise = scl_s & ~scl_prev_q & ~(start_c | stop_c);
  assign scl_fall = ~scl_s & scl_prev_q & ~(start_c | stop_c);
  assign byte_c   = {shift_q, sda_s};
  assign in_ack   = (state_q == S_ADDR_ACK) || (state_q == S_HI_ACK) ||
                    (state_q == S_LO_ACK);

`ifdef MCP4725_PD_EN
  logic [1:0] pd_n_q, pd_q;
  assign pd = pd_q;
`else
  assign pd = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      ack_ph_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      dac_code_q  <= 12'd0;
      dac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      code_hi_q   <= 4'd0;
`ifdef MCP4725_PD_EN
      pd_n_q      <= 2'b00;
      pd_q        <= 2'b00;
`endif
    end else begin
      dac_valid_q <= 1'b0;
      // A running ACK slot is finished before bus conditions are honoured.
      if (start_c && !in_ack) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        ack_ph_q <= 1'b0;
        sda_oe_q <= 1'b0;
      end else if (stop_c && !in_ack) begin
        state_q  <= S_IDLE;
        cnt_q    <= 3'd0;
        ack_ph_q <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_HI, S_LO: begin
            if (scl_rise) begin
              shift_q <= byte_c[6:0];
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                ack_ph_q <= 1'b0;
                if (state_q == S_ADDR) begin
                  if (byte_c == {ADDR7, 1'b0}) begin
                    state_q <= S_ADDR_ACK;
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_HI) begin
                  if (byte_c[7:6] == 2'b00) begin
                    code_hi_q <= byte_c[3:0];
`ifdef MCP4725_PD_EN
                    pd_n_q    <= byte_c[5:4];
`endif
                    state_q   <= S_HI_ACK;
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else begin
                  dac_code_q  <= {code_hi_q, byte_c};
                  dac_valid_q <= 1'b1;
`ifdef MCP4725_PD_EN
                  pd_q        <= pd_n_q;
`endif
                  state_q     <= S_LO_ACK;
                end
              end
            end
          end
          S_ADDR_ACK, S_HI_ACK, S_LO_ACK: begin
            // First SCL fall drives the ACK, the second one releases it.
            if (scl_fall) begin
              if (!ack_ph_q) begin
                sda_oe_q <= 1'b1;
                ack_ph_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                ack_ph_q <= 1'b0;
                cnt_q    <= 3'd0;
                state_q  <= (state_q == S_HI_ACK) ? S_LO : S_HI;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign dac_code  = dac_code_q;
  assign dac_valid = dac_valid_q;
  assign busy      = busy_q;

endmodule
